// File: rtl/ppu_mem_pkg.sv
`default_nettype none
// ==== ppu_mem_pkg: shared types and address constants for the PPU memory arbiter ====
// ==== Rev 1.0 ====
package ppu_mem_pkg;

  typedef enum logic [1:0] {
    MIR_VERT  = 2'b00,
    MIR_HORIZ = 2'b01,
    MIR_SCR_A = 2'b10,
    MIR_SCR_B = 2'b11
  } mirror_mode_t;

  typedef enum logic {
    OWN_RENDER = 1'b0,
    OWN_CPU    = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE  = 2'd2,
    S_RDPEND = 2'd3
  } cpu_state_t;

  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  // pal marks a palette read whose return data is forced to zero
  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   pal;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/ppu_nt_mirror.sv
`default_nettype none
// ==== ppu_nt_mirror: nametable mirroring map plus CHR-ROM / palette region flags ====
// ==== Rev 1.0 ====
module ppu_nt_mirror
  import ppu_mem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [ADDR_W-1:0] addr,
  input  mirror_mode_t      mirror_mode,
  output logic [ADDR_W-1:0] mapped_addr,
  output logic              is_rom,
  output logic              is_pal
);

  logic page;

  always_comb begin
    page = 1'b0;
    case (mirror_mode)
      MIR_VERT:  page = addr[10];
      MIR_HORIZ: page = addr[11];
      MIR_SCR_A: page = 1'b0;
      MIR_SCR_B: page = 1'b1;
      default:   page = 1'b0;
    endcase

    is_rom = ~addr[13];
    is_pal = (addr[13:8] == PAL_BASE[13:8]);

    // $3000-$3EFF folds onto $2000-$2EFF because bits 12 and 11:10 are rebuilt here
    if (addr[13]) begin
      mapped_addr = ADDR_W'(NT_BASE) | ADDR_W'({page, addr[9:0]});
    end else begin
      mapped_addr = addr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppu_mem_arbiter.sv
`default_nettype none
// ==== ppu_mem_arbiter: render/CPU scheduler for the PPU memory port with tagged read return ====
// ==== Rev 1.0 ====
module ppu_mem_arbiter
  import ppu_mem_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mirror_mode,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_gnt,
  output logic              render_rvalid,
  output logic [DATA_W-1:0] render_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  cpu_state_t        state, state_nxt, cpu_phase;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_open, starve_hit, cpu_gnt;
  logic [ADDR_W-1:0] sel_addr, mapped_addr;
  logic              is_rom, is_pal;
  rd_tag_t           new_tag, tail;
  rd_tag_t           tag_pipe [RD_LAT];
  logic [DATA_W-1:0] ret_data;

  // Arbitration: render wins unless the CPU has waited STARVE_LIMIT cycles
  always_comb begin
    cpu_open   = cpu_req && !rst && (state == S_IDLE || state == S_WAIT);
    starve_hit = cpu_open && (starve_cnt == CNT_W'(STARVE_LIMIT));
    render_gnt = render_req && !rst && !starve_hit;
    cpu_gnt    = cpu_open && (!render_req || starve_hit);
    sel_addr   = cpu_gnt ? cpu_addr : render_addr;
  end

  ppu_nt_mirror #(
    .ADDR_W(ADDR_W)
  ) u_mirror (
    .addr       (sel_addr),
    .mirror_mode(mirror_mode_t'(mirror_mode)),
    .mapped_addr(mapped_addr),
    .is_rom     (is_rom),
    .is_pal     (is_pal)
  );

  always_comb begin
    mem_addr  = ((render_gnt || cpu_gnt) && !is_pal) ? mapped_addr : '0;
    mem_we    = cpu_gnt && cpu_we && !is_rom && !is_pal;
    mem_wdata = mem_we ? cpu_wdata : '0;

    new_tag.valid = render_gnt || (cpu_gnt && !cpu_we);
    new_tag.owner = cpu_gnt ? OWN_CPU : OWN_RENDER;
    new_tag.pal   = is_pal;

    tail     = tag_pipe[RD_LAT-1];
    ret_data = tail.pal ? '0 : mem_rdata;
  end

  // The grant cycle is the ISSUE phase; the register itself never rests there
  always_comb begin
    cpu_phase = cpu_gnt ? S_ISSUE : state;
    state_nxt = state;
    case (cpu_phase)
      S_IDLE:   if (cpu_req) state_nxt = S_WAIT;
      S_WAIT:   if (!cpu_req) state_nxt = S_IDLE;
      S_ISSUE:  state_nxt = cpu_we ? S_IDLE : S_RDPEND;
      S_RDPEND: if (tail.valid && tail.owner == OWN_CPU) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    cpu_ack = (cpu_phase == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!cpu_open || cpu_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      render_rvalid <= 1'b0;
      render_rdata  <= '0;
      cpu_rvalid    <= 1'b0;
      cpu_rdata     <= '0;
    end else begin
      render_rvalid <= tail.valid && (tail.owner == OWN_RENDER);
      cpu_rvalid    <= tail.valid && (tail.owner == OWN_CPU);
      if (tail.valid && tail.owner == OWN_RENDER) render_rdata <= ret_data;
      if (tail.valid && tail.owner == OWN_CPU)    cpu_rdata    <= ret_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_mem_arbiter.sv
`default_nettype none
// ==== tb_ppu_mem_arbiter: directed vector table plus multi-cycle sequences ====
// ==== Rev 1.0 ====
module tb_ppu_mem_arbiter;

  localparam int RD_LAT       = 1;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mirror_mode;
  logic        render_req;
  logic [13:0] render_addr;
  logic        render_gnt, render_rvalid;
  logic [7:0]  render_rdata;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  logic mem_init;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  ppu_mem_arbiter #(
    .ADDR_W(14), .DATA_W(8), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .mirror_mode(mirror_mode),
    .render_req(render_req), .render_addr(render_addr), .render_gnt(render_gnt),
    .render_rvalid(render_rvalid), .render_rdata(render_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Memory model with RD_LAT-cycle read pipeline
  logic [7:0] mem [0:16383];
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
      mem[14'h0000] <= 8'hE7;
      mem[14'h0123] <= 8'h5C;
      mem[14'h1000] <= 8'h42;
      mem[14'h2000] <= 8'hD2;
      mem[14'h203F] <= 8'h11;
      mem[14'h243F] <= 8'h77;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) check("pal_never_forwarded", 32'(mem_addr[13:8] == 6'h3F), 32'd0);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_render_gnt"},    32'(render_gnt),    32'd0);
    check({tag, "_render_rvalid"}, 32'(render_rvalid), 32'd0);
    check({tag, "_render_rdata"},  32'(render_rdata),  32'd0);
    check({tag, "_cpu_ack"},       32'(cpu_ack),       32'd0);
    check({tag, "_cpu_rvalid"},    32'(cpu_rvalid),    32'd0);
    check({tag, "_cpu_rdata"},     32'(cpu_rdata),     32'd0);
    check({tag, "_mem_addr"},      32'(mem_addr),      32'd0);
    check({tag, "_mem_wdata"},     32'(mem_wdata),     32'd0);
    check({tag, "_mem_we"},        32'(mem_we),        32'd0);
  endtask

  task automatic idle_inputs();
    render_req = 1'b0; render_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        rreq;
    logic [13:0] raddr;
    logic        creq;
    logic        cwe;
    logic [13:0] caddr;
    logic [7:0]  cwdata;
    logic        e_rgnt;
    logic        e_ack;
    logic [13:0] e_maddr;
    logic        e_we;
    logic        e_rrv;
    logic        e_crv;
    logic [7:0]  e_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // One starvation round: render held, CPU write raised, ack lands exactly at STARVE_LIMIT
  task automatic starve_round(input string tag, input logic [13:0] addr, input logic [7:0] data);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
    for (int k = 0; k <= STARVE_LIMIT; k++) begin
      @(negedge clk);
      check($sformatf("%s_ack_c%0d", tag, k),  32'(cpu_ack),    32'(k == STARVE_LIMIT));
      check($sformatf("%s_rgnt_c%0d", tag, k), 32'(render_gnt), 32'(k != STARVE_LIMIT));
      if (k == STARVE_LIMIT) check({tag, "_maddr"}, 32'(mem_addr), 32'(addr));
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("%s_after_rgnt%0d", tag, k), 32'(render_gnt), 32'd1);
      check($sformatf("%s_after_ack%0d", tag, k),  32'(cpu_ack),    32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              mode  rr  raddr     cr  we  caddr     wdata   rgnt ack maddr     we  rrv crv rdata
    vecs[0]  = '{2'b00, 0, 14'h0000, 1, 1, 14'h2400, 8'hA5,  0, 1, 14'h2400, 1,  0, 0, 8'h00};
    vecs[1]  = '{2'b00, 0, 14'h0000, 1, 0, 14'h2C00, 8'h00,  0, 1, 14'h2400, 0,  0, 1, 8'hA5};
    vecs[2]  = '{2'b01, 0, 14'h0000, 1, 1, 14'h2800, 8'h3C,  0, 1, 14'h2400, 1,  0, 0, 8'h00};
    vecs[3]  = '{2'b11, 1, 14'h2C3F, 0, 0, 14'h0000, 8'h00,  1, 0, 14'h243F, 0,  1, 0, 8'h77};
    vecs[4]  = '{2'b10, 1, 14'h2C3F, 0, 0, 14'h0000, 8'h00,  1, 0, 14'h203F, 0,  1, 0, 8'h11};
    vecs[5]  = '{2'b00, 0, 14'h0000, 1, 1, 14'h1000, 8'h99,  0, 1, 14'h1000, 0,  0, 0, 8'h00};
    vecs[6]  = '{2'b00, 0, 14'h0000, 1, 0, 14'h1000, 8'h00,  0, 1, 14'h1000, 0,  0, 1, 8'h42};
    vecs[7]  = '{2'b00, 0, 14'h0000, 1, 0, 14'h3F10, 8'h00,  0, 1, 14'h0000, 0,  0, 1, 8'h00};
    vecs[8]  = '{2'b00, 1, 14'h0123, 0, 0, 14'h0000, 8'h00,  1, 0, 14'h0123, 0,  1, 0, 8'h5C};
    vecs[9]  = '{2'b01, 0, 14'h0000, 1, 0, 14'h3400, 8'h00,  0, 1, 14'h2000, 0,  0, 1, 8'hD2};
    vecs[10] = '{2'b00, 0, 14'h0000, 1, 1, 14'h3F00, 8'h55,  0, 1, 14'h0000, 0,  0, 0, 8'h00};
    vecs[11] = '{2'b00, 1, 14'h2400, 0, 0, 14'h0000, 8'h00,  1, 0, 14'h2400, 0,  1, 0, 8'h3C};
    vecs[12] = '{2'b00, 0, 14'h0000, 0, 0, 14'h0000, 8'h00,  0, 0, 14'h0000, 0,  0, 0, 8'h00};
    vecs[13] = '{2'b01, 1, 14'h3EFF, 0, 0, 14'h0000, 8'h00,  1, 0, 14'h26FF, 0,  1, 0, 8'h00};
    vecs[14] = '{2'b00, 1, 14'h3F00, 0, 0, 14'h0000, 8'h00,  1, 0, 14'h0000, 0,  1, 0, 8'h00};

    idle_inputs();
    mirror_mode = 2'b00;
    rst = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      mirror_mode = vecs[i].mode;
      render_req = vecs[i].rreq; render_addr = vecs[i].raddr;
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      @(negedge clk);
      check($sformatf("v%0d_rgnt", i),  32'(render_gnt), 32'(vecs[i].e_rgnt));
      check($sformatf("v%0d_ack", i),   32'(cpu_ack),    32'(vecs[i].e_ack));
      check($sformatf("v%0d_maddr", i), 32'(mem_addr),   32'(vecs[i].e_maddr));
      check($sformatf("v%0d_we", i),    32'(mem_we),     32'(vecs[i].e_we));
      @(posedge clk); #1;
      idle_inputs();
      repeat (RD_LAT) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_rrv", i), 32'(render_rvalid), 32'(vecs[i].e_rrv));
      check($sformatf("v%0d_crv", i), 32'(cpu_rvalid),    32'(vecs[i].e_crv));
      if (vecs[i].e_rrv) check($sformatf("v%0d_rrdata", i), 32'(render_rdata), 32'(vecs[i].e_rdata));
      if (vecs[i].e_crv) check($sformatf("v%0d_crdata", i), 32'(cpu_rdata),    32'(vecs[i].e_rdata));
    end

    // Starvation: two rounds back to back show the counter restarts from zero
    @(posedge clk); #1;
    mirror_mode = 2'b00;
    render_req = 1'b1; render_addr = 14'h0123;
    starve_round("starve1", 14'h2001, 8'h5A);
    starve_round("starve2", 14'h2002, 8'h6B);
    idle_inputs();
    repeat (RD_LAT + 2) @(posedge clk);
    #1;

    // Render then CPU read issued back to back: returns in issue order, no cross-delivery
    render_req = 1'b1; render_addr = 14'h0123;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
    @(negedge clk);
    check("b2b_c0_rgnt", 32'(render_gnt), 32'd1);
    check("b2b_c0_ack",  32'(cpu_ack),    32'd0);
    @(posedge clk); #1 render_req = 1'b0;
    @(negedge clk);
    check("b2b_c1_rgnt",  32'(render_gnt), 32'd0);
    check("b2b_c1_ack",   32'(cpu_ack),    32'd1);
    check("b2b_c1_maddr", 32'(mem_addr),   32'h2000);
    @(posedge clk); #1 cpu_req = 1'b0;
    for (int c = 2; c <= RD_LAT + 3; c++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d_rrv", c), 32'(render_rvalid), 32'(c == RD_LAT + 1));
      check($sformatf("b2b_c%0d_crv", c), 32'(cpu_rvalid),    32'(c == RD_LAT + 2));
      if (c == RD_LAT + 1) check("b2b_rrdata", 32'(render_rdata), 32'h5C);
      if (c == RD_LAT + 2) begin
        check("b2b_crdata", 32'(cpu_rdata), 32'hD2);
        check("b2b_rrdata_hold", 32'(render_rdata), 32'h5C);
      end
      @(posedge clk); #1;
    end

    // Reset one cycle after a CPU read ack discards the in-flight return
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2400;
    @(negedge clk);
    check("rst_seq_ack", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_seq");
    for (int c = 0; c < RD_LAT + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_seq_no_crv%0d", c), 32'(cpu_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2400;
    @(negedge clk);
    check("post_rst_ack", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1 cpu_req = 1'b0;
    repeat (RD_LAT) @(posedge clk);
    @(negedge clk);
    check("post_rst_crv",    32'(cpu_rvalid), 32'd1);
    check("post_rst_crdata", 32'(cpu_rdata),  32'h3C);

    @(posedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
